// File: rtl/mac_tx_arb_pkg.sv
// Shared types and default constants for the MAC transmit arbiter and its helpers.
package mac_tx_arb_pkg;

    localparam int DEF_IFG_CYCLES    = 12;
    localparam int DEF_MAX_FRAME_LEN = 1514;

    typedef enum logic [1:0] {
        IDLE,
        XFER,
        DRAIN,
        GAP
    } arb_state_t;

endpackage

// File: rtl/mac_rr_pick.sv
// Round-robin picker: first set request bit searching upward from ptr+1 (mod NUM_REQ).
module mac_rr_pick #(
    parameter  int NUM_REQ = 3,
    localparam int IW      = $clog2(NUM_REQ)
) (
    input  logic [NUM_REQ-1:0] req,
    input  logic [IW-1:0]      ptr,
    output logic               found,
    output logic [IW-1:0]      idx
);

    int          cand;
    logic [IW-1:0] cand_idx;

    // Walk from the farthest candidate to the nearest so the nearest set bit wins.
    always_comb begin
        found    = |req;
        idx      = '0;
        cand     = 0;
        cand_idx = '0;
        for (int i = NUM_REQ; i >= 1; i--) begin
            cand     = (int'(ptr) + i) % NUM_REQ;
            cand_idx = IW'(cand);
            if (req[cand_idx]) begin
                idx = cand_idx;
            end
        end
    end

endmodule

// File: rtl/mac_tx_arbiter.sv
// Frame-locked round-robin arbiter sharing one MAC TX byte stream between NUM_REQ sources,
// with inter-frame gap insertion and truncation of over-length frames.
module mac_tx_arbiter
    import mac_tx_arb_pkg::*;
#(
    parameter  int NUM_REQ       = 3,
    parameter  int IFG_CYCLES    = DEF_IFG_CYCLES,
    parameter  int MAX_FRAME_LEN = DEF_MAX_FRAME_LEN,
    localparam int IW            = $clog2(NUM_REQ)
) (
    input  logic                 logic_clk,
    input  logic                 logic_rst,
    input  logic [NUM_REQ*8-1:0] req_data_in,
    input  logic [NUM_REQ-1:0]   req_valid_in,
    input  logic [NUM_REQ-1:0]   req_last_in,
    output logic [NUM_REQ-1:0]   req_ready_out,
    output logic [7:0]           mac_rnet_data_out,
    output logic                 mac_rnet_valid_out,
    output logic                 mac_rnet_last_out,
    input  logic                 mac_rnet_ready_in,
    output logic [IW-1:0]        grant_id_out,
    output logic                 busy_out,
    output logic                 trunc_pulse_out
);

    localparam int BW = $clog2(MAX_FRAME_LEN + 1);
    localparam int GW = (IFG_CYCLES > 0) ? $clog2(IFG_CYCLES + 1) : 1;
    localparam arb_state_t END_STATE = (IFG_CYCLES == 0) ? IDLE : GAP;

    arb_state_t    state;
    arb_state_t    next_state;
    logic [IW-1:0] rr_ptr;
    logic [IW-1:0] grant;
    logic [BW-1:0] byte_cnt;
    logic [GW-1:0] gap_cnt;
    logic          trunc_pulse;
    logic          pick_found;
    logic [IW-1:0] pick_idx;
    logic          own_valid;
    logic          own_last;
    logic          beat;
    logic          trunc_hit;

    mac_rr_pick #(.NUM_REQ(NUM_REQ)) u_pick (
        .req   (req_valid_in),
        .ptr   (rr_ptr),
        .found (pick_found),
        .idx   (pick_idx)
    );

    always_ff @(posedge logic_clk or posedge logic_rst) begin
        if (logic_rst) begin
            state <= IDLE;
        end else begin
            state <= next_state;
        end
    end

    // The owner's handshake is passed straight through; DRAIN swallows the tail of a truncated frame.
    always_comb begin
        next_state         = state;
        req_ready_out      = '0;
        mac_rnet_data_out  = 8'h00;
        mac_rnet_valid_out = 1'b0;
        mac_rnet_last_out  = 1'b0;
        beat               = 1'b0;
        own_valid          = req_valid_in[grant];
        own_last           = req_last_in[grant];
        trunc_hit          = (byte_cnt == BW'(MAX_FRAME_LEN - 1));
        case (state)
            IDLE: begin
                if (pick_found) begin
                    next_state = XFER;
                end
            end
            XFER: begin
                for (int i = 0; i < NUM_REQ; i++) begin
                    if (grant == IW'(i)) begin
                        mac_rnet_data_out = req_data_in[i*8 +: 8];
                    end
                end
                mac_rnet_valid_out   = own_valid;
                mac_rnet_last_out    = own_last | trunc_hit;
                req_ready_out[grant] = mac_rnet_ready_in;
                beat                 = own_valid & mac_rnet_ready_in;
                if (beat && own_last) begin
                    next_state = END_STATE;
                end else if (beat && trunc_hit) begin
                    next_state = DRAIN;
                end
            end
            DRAIN: begin
                req_ready_out[grant] = 1'b1;
                beat                 = own_valid;
                if (beat && own_last) begin
                    next_state = END_STATE;
                end
            end
            GAP: begin
                if (gap_cnt == GW'(IFG_CYCLES - 1)) begin
                    next_state = IDLE;
                end
            end
            default: next_state = IDLE;
        endcase
    end

    always_ff @(posedge logic_clk or posedge logic_rst) begin
        if (logic_rst) begin
            rr_ptr      <= IW'(NUM_REQ - 1);
            grant       <= '0;
            byte_cnt    <= '0;
            gap_cnt     <= '0;
            trunc_pulse <= 1'b0;
        end else begin
            trunc_pulse <= (state == XFER) && beat && trunc_hit && !own_last;
            gap_cnt     <= (state == GAP) ? gap_cnt + GW'(1) : '0;
            if (state == IDLE && pick_found) begin
                grant  <= pick_idx;
                rr_ptr <= pick_idx;
            end
            // Counter saturates at MAX_FRAME_LEN so a long drain can never wrap it.
            if ((state == XFER || state == DRAIN) && beat) begin
                if (own_last) begin
                    byte_cnt <= '0;
                end else if (byte_cnt != BW'(MAX_FRAME_LEN)) begin
                    byte_cnt <= byte_cnt + BW'(1);
                end
            end
        end
    end

    assign grant_id_out    = grant;
    assign busy_out        = (state != IDLE);
    assign trunc_pulse_out = trunc_pulse;

endmodule

// File: tb/tb_mac_tx_arbiter.sv
// Self-checking bench for mac_tx_arbiter: scenario table plus hand-written latency and reset sequences.
module tb_mac_tx_arbiter;

    localparam int NR   = 3;
    localparam int IFG  = 12;
    localparam int MAXL = 100;

    typedef struct packed {
        logic [7:0] data;
        logic       last;
        logic [1:0] owner;
        logic       first;
        logic       forced;
    } exp_t;

    typedef struct {
        logic [2:0]       mask;
        int               len0;
        int               len1;
        int               len2;
        int               nframes;
        bit               toggle;
        int               hold_req;
        int               hold_at;
        int               hold_len;
        logic [5:0][1:0]  grants;
        int               n_grants;
        int               exp_trunc;
        bit               spacing;
    } scen_t;

    logic          clk = 1'b0;
    logic          rst = 1'b0;
    logic [23:0]   req_data = '0;
    logic [2:0]    req_valid = '0;
    logic [2:0]    req_last = '0;
    logic [2:0]    req_ready;
    logic [7:0]    mac_data;
    logic          mac_valid;
    logic          mac_last;
    logic          mac_ready = 1'b1;
    logic [1:0]    grant_id;
    logic          busy;
    logic          trunc;

    int n_checks = 0;
    int n_errors = 0;
    int cycle = 0;
    int frames_left[NR];
    int flen[NR];
    int idx[NR];
    int hold_cnt[NR];
    bit hold_used;
    exp_t sb[$];
    int got_grants[$];
    int end_cycle;
    int gap_busy;
    int trunc_seen;
    int mac_beats;
    int forced_cycle;
    bit meas;
    scen_t cur;
    scen_t vec[7];

    always #5 clk = ~clk;

    mac_tx_arbiter #(.NUM_REQ(NR), .IFG_CYCLES(IFG), .MAX_FRAME_LEN(MAXL)) dut (
        .logic_clk          (clk),
        .logic_rst          (rst),
        .req_data_in        (req_data),
        .req_valid_in       (req_valid),
        .req_last_in        (req_last),
        .req_ready_out      (req_ready),
        .mac_rnet_data_out  (mac_data),
        .mac_rnet_valid_out (mac_valid),
        .mac_rnet_last_out  (mac_last),
        .mac_rnet_ready_in  (mac_ready),
        .grant_id_out       (grant_id),
        .busy_out           (busy),
        .trunc_pulse_out    (trunc)
    );

    initial begin
        #1000000;
        $display("[TB] FAIL watchdog: simulation time limit reached");
        $fatal(1, "[TB] watchdog");
    end

    function automatic scen_t mk(logic [2:0] m, int l0, int l1, int l2, int nf, bit tog,
                                 int hr, int ha, int hl, logic [11:0] g, int ng, int tr, bit sp);
        scen_t s;
        s.mask = m; s.len0 = l0; s.len1 = l1; s.len2 = l2; s.nframes = nf; s.toggle = tog;
        s.hold_req = hr; s.hold_at = ha; s.hold_len = hl; s.grants = g; s.n_grants = ng;
        s.exp_trunc = tr; s.spacing = sp;
        return s;
    endfunction

    function automatic int len_of(scen_t s, int i);
        return (i == 0) ? s.len0 : (i == 1) ? s.len1 : s.len2;
    endfunction

    function automatic int exp_beats(scen_t s);
        int total = 0;
        for (int i = 0; i < NR; i++) begin
            if (s.mask[i]) total += s.nframes * ((len_of(s, i) < MAXL) ? len_of(s, i) : MAXL);
        end
        return total;
    endfunction

    function automatic logic [7:0] byte_of(int i, int n);
        return 8'((n * 3 + i * 77 + 1) % 256);
    endfunction

    function automatic bit sources_done();
        for (int i = 0; i < NR; i++) if (frames_left[i] != 0) return 1'b0;
        return 1'b1;
    endfunction

    task automatic check_output(input bit ok, input string name, input int act, input int req);
        n_checks++;
        if (!ok) begin
            n_errors++;
            $display("[TB] FAIL %s: got %0d, expected %0d (cycle %0d)", name, act, req, cycle);
        end
    endtask

    task automatic drive_sources();
        for (int i = 0; i < NR; i++) begin
            req_valid[i]        = (frames_left[i] > 0) && (hold_cnt[i] == 0);
            req_data[i*8 +: 8]  = byte_of(i, idx[i]);
            req_last[i]         = (idx[i] == flen[i] - 1);
        end
    endtask

    task automatic init_sources();
        for (int i = 0; i < NR; i++) begin
            frames_left[i] = cur.mask[i] ? cur.nframes : 0;
            flen[i]        = len_of(cur, i);
            idx[i]         = 0;
            hold_cnt[i]    = 0;
        end
        hold_used    = 1'b0;
        sb.delete();
        got_grants.delete();
        end_cycle    = -1;
        meas         = 1'b0;
        gap_busy     = 0;
        trunc_seen   = 0;
        mac_beats    = 0;
        forced_cycle = -10;
        mac_ready    = 1'b1;
        drive_sources();
    endtask

    task automatic apply_reset();
        rst       = 1'b1;
        req_valid = '0;
        req_last  = '0;
        req_data  = '0;
        mac_ready = 1'b1;
        @(posedge clk);
        #1;
        check_output(!busy && !mac_valid && !mac_last && req_ready == 3'b000 && grant_id == 2'd0 && !trunc,
                     "reset_state", int'({busy, mac_valid, mac_last, req_ready, grant_id, trunc}), 0);
        @(negedge clk);
        rst = 1'b0;
    endtask

    // One clock: observe at the falling edge, advance the sources just after the rising edge.
    task automatic apply_stimulus();
        logic [2:0] acc;
        logic [2:0] own;
        exp_t       e;
        int         bi;
        @(negedge clk);
        acc = req_valid & req_ready;
        own = busy ? (3'b001 << grant_id) : 3'b000;
        check_output(((req_ready & ~own) == 3'b000) && !(mac_valid && !busy), "ready_owner",
                     int'({mac_valid, req_ready}), int'(own));
        if (trunc) begin
            trunc_seen++;
            check_output(cycle == forced_cycle + 1, "trunc_timing", cycle, forced_cycle + 1);
        end
        for (int i = 0; i < NR; i++) begin
            if (hold_cnt[i] > 0) check_output(busy && grant_id == 2'(i), "grant_held", int'(grant_id), i);
        end
        if (meas) begin
            if (busy) gap_busy++;
            else begin
                meas = 1'b0;
                check_output(gap_busy == IFG, "gap_len", gap_busy, IFG);
            end
        end
        for (int i = 0; i < NR; i++) begin
            if (acc[i]) begin
                bi = idx[i];
                if (bi < MAXL) begin
                    check_output(mac_ready, "accept_ready_low", int'(mac_ready), 1);
                    e.data   = byte_of(i, bi);
                    e.last   = (bi == flen[i] - 1) || (bi == MAXL - 1);
                    e.owner  = 2'(i);
                    e.first  = (bi == 0);
                    e.forced = (bi == MAXL - 1) && (bi != flen[i] - 1);
                    sb.push_back(e);
                end else begin
                    check_output(!mac_valid, "drain_valid", int'(mac_valid), 0);
                end
                if (bi == flen[i] - 1) begin
                    end_cycle = cycle;
                    meas      = 1'b1;
                    gap_busy  = 0;
                end
            end
        end
        if (mac_valid && mac_ready) begin
            check_output(sb.size() != 0, "spurious_beat", sb.size(), 1);
            if (sb.size() != 0) begin
                e = sb.pop_front();
                check_output(mac_data == e.data && mac_last == e.last && grant_id == e.owner, "beat",
                             int'({mac_data, mac_last, grant_id}), int'({e.data, e.last, e.owner}));
                if (e.first) begin
                    got_grants.push_back(int'(e.owner));
                    if (cur.spacing && end_cycle >= 0)
                        check_output(cycle - end_cycle == IFG + 2, "spacing", cycle - end_cycle, IFG + 2);
                end
                if (e.forced) forced_cycle = cycle;
                mac_beats++;
            end
        end
        @(posedge clk);
        #1;
        cycle++;
        for (int i = 0; i < NR; i++) if (hold_cnt[i] > 0) hold_cnt[i]--;
        for (int i = 0; i < NR; i++) begin
            if (acc[i]) begin
                idx[i]++;
                if (idx[i] == flen[i]) begin
                    idx[i] = 0;
                    frames_left[i]--;
                end
                if (i == cur.hold_req && !hold_used && cur.hold_len > 0 && idx[i] == cur.hold_at) begin
                    hold_cnt[i] = cur.hold_len;
                    hold_used   = 1'b1;
                end
            end
        end
        if (cur.toggle) mac_ready = ~mac_ready;
        drive_sources();
    endtask

    task automatic run_until_done();
        int budget = 0;
        while (!(sources_done() && !meas) && budget < 4000) begin
            apply_stimulus();
            budget++;
        end
        check_output(budget < 4000, "timeout", budget, 4000);
        check_output(got_grants.size() == cur.n_grants, "grant_count", got_grants.size(), cur.n_grants);
        for (int k = 0; k < cur.n_grants && k < got_grants.size(); k++)
            check_output(got_grants[k] == int'(cur.grants[k]), "grant_order", got_grants[k], int'(cur.grants[k]));
        check_output(trunc_seen == cur.exp_trunc, "trunc_count", trunc_seen, cur.exp_trunc);
        check_output(mac_beats == exp_beats(cur), "beat_count", mac_beats, exp_beats(cur));
        check_output(sb.size() == 0, "sb_empty", sb.size(), 0);
    endtask

    initial begin
        int b;
        vec[0] = mk(3'b001,  60,  0,  0, 1, 0, -1,  0, 0, {2'd0,2'd0,2'd0,2'd0,2'd0,2'd0}, 1, 0, 0);
        vec[1] = mk(3'b111,  64, 64, 64, 2, 0, -1,  0, 0, {2'd2,2'd1,2'd0,2'd2,2'd1,2'd0}, 6, 0, 1);
        vec[2] = mk(3'b110,   0, 40, 20, 1, 1,  1, 10, 5, {2'd0,2'd0,2'd0,2'd0,2'd2,2'd1}, 2, 0, 0);
        vec[3] = mk(3'b001, 150,  0,  0, 1, 0, -1,  0, 0, {2'd0,2'd0,2'd0,2'd0,2'd0,2'd0}, 1, 1, 0);
        vec[4] = mk(3'b001, 100,  0,  0, 1, 0, -1,  0, 0, {2'd0,2'd0,2'd0,2'd0,2'd0,2'd0}, 1, 0, 0);
        vec[5] = mk(3'b011, 150, 10,  0, 1, 0, -1,  0, 0, {2'd0,2'd0,2'd0,2'd0,2'd1,2'd0}, 2, 1, 1);
        vec[6] = mk(3'b101,   5,  0,  5, 2, 0, -1,  0, 0, {2'd0,2'd0,2'd2,2'd0,2'd2,2'd0}, 4, 0, 1);

        // Grant latency: a request seen in IDLE produces no outputs until the next cycle.
        cur = vec[0];
        apply_reset();
        req_valid = 3'b010;
        req_data  = 24'h00_5A_00;
        #1;
        check_output(!busy && req_ready == 3'b000 && !mac_valid, "idle_no_outputs",
                     int'({busy, req_ready, mac_valid}), 0);
        @(negedge clk);
        check_output(grant_id == 2'd1 && busy && req_ready == 3'b010 && mac_valid && mac_data == 8'h5A,
                     "grant_latency", int'({grant_id, busy, req_ready, mac_valid}), int'({2'd1, 1'b1, 3'b010, 1'b1}));

        for (int v = 0; v < 7; v++) begin
            cur = vec[v];
            $display("[TB] scenario %0d", v);
            apply_reset();
            init_sources();
            run_until_done();
        end

        // Reset in the middle of a frame from requester 0 while requester 2 is also waiting.
        $display("[TB] reset mid-frame");
        cur = mk(3'b101, 60, 0, 60, 1, 0, -1, 0, 0, {2'd0,2'd0,2'd0,2'd0,2'd2,2'd0}, 2, 0, 1);
        apply_reset();
        init_sources();
        b = 0;
        while (idx[0] != 29 && b < 200) begin
            apply_stimulus();
            b++;
        end
        check_output(b < 200, "reach_byte30", b, 200);
        #2;
        rst = 1'b1;
        #1;
        check_output(!busy && !mac_valid && !mac_last && mac_data == 8'h00 && req_ready == 3'b000 &&
                     grant_id == 2'd0 && !trunc, "async_reset",
                     int'({busy, mac_valid, mac_last, req_ready, grant_id, trunc}), 0);
        @(posedge clk);
        @(negedge clk);
        rst = 1'b0;
        init_sources();
        run_until_done();

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule

// File: doc/mac_tx_arbiter.md
Name: mac_tx_arbiter

Overview:
- Shares the single MAC transmit byte stream (mac_rnet_* input of the MAC TX CRC path) between NUM_REQ upstream frame sources, e.g. ARP, ICMP and UDP.
- Grants are round-robin and frame-locked: once a source is granted, it owns the stream until its last byte.
- Enforces an idle gap between frames.
- Truncates runaway frames at MAX_FRAME_LEN bytes.

Parameters:
- NUM_REQ, 3: number of requesters (2..8).
- IFG_CYCLES, 12: idle cycles forced after each frame end. 0 means no gap.
- MAX_FRAME_LEN, 1514: maximum bytes forwarded per frame before forced truncation.

Ports:
- logic_clk  in  1  clock.
- logic_rst  in  1  reset, asynchronous, active-high.
- req_data_in  in  NUM_REQ*8  byte per requester; requester i uses bits [8i+7:8i].
- req_valid_in  in  NUM_REQ  per-requester valid.
- req_last_in  in  NUM_REQ  per-requester last byte of frame.
- req_ready_out  out  NUM_REQ  per-requester ready.
- mac_rnet_data_out  out  8  byte to MAC TX.
- mac_rnet_valid_out  out  1  valid to MAC TX.
- mac_rnet_last_out  out  1  last to MAC TX.
- mac_rnet_ready_in  in  1  ready from MAC TX.
- grant_id_out  out  $clog2(NUM_REQ)  index of the current or most recent owner.
- busy_out  out  1  high in any state other than IDLE.
- trunc_pulse_out  out  1  one-cycle pulse when a frame is truncated.

Behaviour:
- Reset (async assert, sync release):
  - state = IDLE, rr_ptr = NUM_REQ-1 so requester 0 wins first, byte_cnt = 0, grant_id_out = 0.
  - All outputs 0, including req_ready_out and mac_rnet_valid_out.
- Reset mid-frame aborts immediately: no last is emitted and all state returns to its reset value.
- Handshake: a beat transfers when valid & ready are both high in the same cycle. Forwarding is combinational (zero latency); no skid buffer.
- IDLE:
  - If any req_valid_in bit is high, pick the first set bit searching upward from rr_ptr+1 (mod NUM_REQ).
  - Register the result into grant_id_out and rr_ptr, then go to XFER next cycle. Grant latency is 1 cycle.
  - No outputs are asserted in IDLE.
- XFER, owner g:
  - mac_rnet_data_out = req_data_in[g].
  - mac_rnet_valid_out = req_valid_in[g].
  - mac_rnet_last_out = req_last_in[g] | trunc_hit.
  - req_ready_out[g] = mac_rnet_ready_in; all other ready bits are 0.
  - A source deasserting valid mid-frame keeps the grant (no timeout).
  - byte_cnt increments on each accepted beat.
  - trunc_hit = (byte_cnt == MAX_FRAME_LEN-1).
  - On an accepted beat with req_last_in[g]: go to GAP (or to IDLE if IFG_CYCLES = 0) and clear byte_cnt.
  - On an accepted beat with trunc_hit & !req_last_in[g]: forward it with last forced high, pulse trunc_pulse_out next cycle, go to DRAIN.
  - Source last and trunc_hit on the same beat: treat as a normal end, with no trunc pulse.
- DRAIN:
  - req_ready_out[g] = 1 and mac_rnet_valid_out = 0; beats from g are discarded.
  - On an accepted beat with last, go to GAP/IDLE and clear byte_cnt.
- GAP:
  - gap_cnt counts 0..IFG_CYCLES-1; all ready and valid outputs are 0.
  - After the final gap cycle, go to IDLE.
  - First-to-last beat spacing between back-to-back frames is exactly IFG_CYCLES+2 cycles: last beat, IFG_CYCLES gap cycles, 1 IDLE cycle, then the first beat.
- Fairness:
  - rr_ptr changes only at grant, so a requester waiting while others transmit is served within NUM_REQ-1 frames.
  - Simultaneous requests resolve purely by rr_ptr.
- Width rules:
  - byte_cnt is $clog2(MAX_FRAME_LEN+1) bits and saturates; it is never allowed to wrap.
  - gap_cnt is $clog2(IFG_CYCLES+1) bits, minimum 1.
- Invariants (for assertions):
  - At most one req_ready_out bit is high.
  - mac_rnet_valid_out is never high outside XFER.

Decomposition:
- Package mac_tx_arb_pkg: state enum arb_state_t {IDLE, XFER, DRAIN, GAP}.
- mac_tx_arb_pkg also holds the default constants: IFG default 12, max frame 1514.
- One combinational sub-module, mac_rr_pick: inputs request vector and pointer; outputs found flag and index. Reusable by the future RX demux.

Test Plan:
- Reset, then req_valid_in=3'b001 with a 60-byte frame and ready tied high:
  - grant_id_out=0 one cycle after valid.
  - 60 beats out with last on beat 60, followed by 12 idle cycles.
- All three requesters continuously valid with 64-byte frames:
  - Grant order 0,1,2,0,1,2.
  - Inter-frame spacing exactly 14 cycles, last to first beat.
  - No ready high on any non-owner.
- Owner 1 mid-frame with mac_rnet_ready_in toggling 1010..., valid dropped for 5 cycles:
  - Byte order and count are preserved.
  - Grant is held.
  - No beats are accepted while ready is low.
- MAX_FRAME_LEN=100, source sends 150 bytes:
  - 100 bytes forwarded, with last on byte 100.
  - trunc_pulse_out is high for 1 cycle.
  - The remaining 50 bytes are accepted and discarded; no MAC valid during DRAIN.
  - GAP is entered after source last.
- Source frame of exactly 100 bytes with MAX_FRAME_LEN=100: normal end, no trunc pulse, no DRAIN.
- Assert logic_rst during byte 30 of a frame:
  - Outputs are 0 asynchronously.
  - After release, requester 0 is granted first even though requester 2 is also valid.
